pipe_ctrl: RTL

Pipeline control unit for the 5-stage MIPS32 core. It generates the per-stage stall vector and the pipeline flush/redirect consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Sequences exception/ERET entry: an exception is held pending until any outstanding memory access completes, then the pipeline is frozen for one cycle and flushed for one cycle.
- Watchdogs stuck memory stalls.
- Counts stall cycles for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_stall_watchdog.sv | 36 +++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall-vector encodings,
// FSM state encoding, the default exception vector and the latched request type.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned WDOG_W  = 16;

  // Stall vector bit 0 holds the PC; higher bits hold IF, ID, EX, MEM, WB.
  localparam int unsigned STALL_PC = 0;

  localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID_REQ  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX_REQ  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM_REQ = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL     = 6'b111111;

  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'h8000_1180;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // Exception request captured while a memory access is still outstanding.
  typedef struct packed {
    logic              eret;
    logic [ADDR_W-1:0] epc;
  } exc_req_t;

  // RUN-state stall vector, deepest requester wins.
  function automatic logic [STALL_W-1:0] run_stall(input logic req_id,
                                                   input logic req_ex,
                                                   input logic req_mem);
    logic [STALL_W-1:0] v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_MEM_REQ;
    else if (req_ex) v = STALL_EX_REQ;
    else if (req_id) v = STALL_ID_REQ;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Memory-stall watchdog: counts consecutive RUN cycles with stallreq_mem high
// and strobes timeout_c on the TIMEOUT-th such cycle.
//   clk, rst      : core clock, synchronous active-high reset
//   run           : controller is in RUN
//   stallreq_mem  : memory access in progress
//   timeout_c     : combinational strobe, high on the timing-out cycle
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic stallreq_mem,
  output logic timeout_c
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q;

  assign timeout_c = run && stallreq_mem && (cnt_q == LAST);

  // Count consecutive stalled RUN cycles; restart after a timeout fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (run && stallreq_mem && !timeout_c) begin
      cnt_q <= cnt_q + WDOG_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage MIPS32 core: stall vector, exception
// and ERET sequencing (defer on memory, freeze one cycle, flush one cycle),
// memory-stall watchdog and a saturating stall-cycle counter.
//   clk, rst                  : core clock, synchronous active-high reset
//   stallreq_id/ex/mem        : per-stage stall requests
//   exc_valid, exc_is_eret    : exception / ERET from MEM
//   cp0_epc                   : return address for ERET
//   perf_clr                  : clears stall_cycles
//   stall                     : per-stage hold vector (combinational in RUN)
//   flush, new_pc             : one-cycle flush and redirect target
//   bus_timeout               : flush was caused by the watchdog
//   stall_cycles              : saturating count of cycles with the PC held
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              exc_valid,
  input  logic              exc_is_eret,
  input  logic [ADDR_W-1:0] cp0_epc,
  input  logic              perf_clr,
  output logic [STALL_W-1:0] stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              bus_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_e   state_q;
  logic     pend_q;
  exc_req_t pend_req_q;
  logic     tmo_q;
  logic     run;
  logic     timeout_c;
  logic     accept;
  logic     take_eret;
  logic [ADDR_W-1:0] take_epc;

  assign run       = (state_q == ST_RUN);
  // First exception wins: a latched request shadows the live inputs.
  assign take_eret = pend_q ? pend_req_q.eret : exc_is_eret;
  assign take_epc  = pend_q ? pend_req_q.epc  : cp0_epc;
  assign accept    = run && (exc_valid || pend_q) && !stallreq_mem;

  pipe_ctrl_stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .stallreq_mem (stallreq_mem),
    .timeout_c    (timeout_c)
  );

  // Stall vector: request priority in RUN, full hold in FREEZE, none in FLUSH.
  always_comb begin
    stall = STALL_NONE;
    case (state_q)
      ST_RUN:    stall = run_stall(stallreq_id, stallreq_ex, stallreq_mem);
      ST_FREEZE: stall = STALL_ALL;
      default:   stall = STALL_NONE;
    endcase
  end

  // Exception sequencing FSM with registered flush/new_pc/bus_timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      pend_req_q  <= '0;
      tmo_q       <= 1'b0;
      flush       <= 1'b0;
      new_pc      <= '0;
      bus_timeout <= 1'b0;
    end else begin
      flush       <= 1'b0;
      bus_timeout <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (timeout_c) begin
            // Watchdog overrides any pending exception or ERET.
            state_q <= ST_FREEZE;
            new_pc  <= EXC_VECTOR;
            pend_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else if (accept) begin
            state_q <= ST_FREEZE;
            new_pc  <= take_eret ? take_epc : EXC_VECTOR;
            pend_q  <= 1'b0;
            tmo_q   <= 1'b0;
          end else if (exc_valid && !pend_q) begin
            pend_q     <= 1'b1;
            pend_req_q <= '{eret: exc_is_eret, epc: cp0_epc};
          end
        end
        ST_FREEZE: begin
          state_q     <= ST_FLUSH;
          flush       <= 1'b1;
          bus_timeout <= tmo_q;
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
          tmo_q   <= 1'b0;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cycles <= '0;
    end else if (stall[STALL_PC] && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
